// File: rtl/uart_rx_fifo_core_pkg.sv
// Shared UART definitions: receiver state encoding, character constants and
// the FIFO pointer-width helper used by the RX path (and later the TX path).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned UART_MIN_DIV   = 4;

    // One extra bit beyond the address so full and empty can be told apart
    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_core_if.sv
// Read/status side of the UART receiver: the CSR layer (master) pops bytes
// and clears sticky errors; the core (slave) presents FIFO head and flags.
interface uart_rx_fifo_core_if;

    logic                                 rd_en;
    logic                                 err_clr;
    logic [uart_pkg::UART_DATA_BITS-1:0]  rd_data;
    logic                                 rx_valid;
    logic                                 fifo_full;
    logic                                 frame_err;
    logic                                 overrun_err;
    logic                                 parity_err;
    logic                                 irq;

    modport master (
        output rd_en, err_clr,
        input  rd_data, rx_valid, fifo_full, frame_err, overrun_err, parity_err, irq
    );

    modport slave (
        input  rd_en, err_clr,
        output rd_data, rx_valid, fifo_full, frame_err, overrun_err, parity_err, irq
    );

endinterface

// File: rtl/uart_rx_fifo_core_fifo.sv
// Generic first-word-fall-through FIFO; head, valid and full are registered
// from next-state so they change the cycle after a push or pop.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             valid_d_c,
    output logic             drop_c
);

    localparam int unsigned PW = fifo_ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, full_q, full_d;
    logic             empty, full, do_pop, do_push, empty_d;

    // A push into a full FIFO still lands when the head is popped in the same cycle
    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop_i && !empty;
        do_push = push_i && (!full || do_pop);
        mem_d   = mem_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = data_i;
        end
        wr_d    = wr_q + PW'(do_push);
        rd_d    = rd_q + PW'(do_pop);
        empty_d = (wr_d == rd_d);
        full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
        data_d  = empty_d ? '0 : mem_d[rd_d[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            valid_q <= !empty_d;
            full_q  <= full_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign full_o    = full_q;
    assign valid_d_c = !empty_d;
    assign drop_c    = push_i && !do_push;

endmodule

// File: rtl/uart_rx_fifo_core.sv
// UART 8N1 receiver with FWFT byte FIFO, sticky error flags and level irq.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_fifo_core
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 rx_i,
    input  logic                 rx_en,
    input  logic [15:0]          clk_div,
    uart_rx_fifo_core_if.slave   bus
);

    localparam int unsigned BW = $clog2(UART_DATA_BITS);

    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      rxs;
    rx_state_e                 state_q, state_d;
    logic [15:0]               cnt_q, cnt_d, div_q, div_d, div_lim;
    logic [BW-1:0]             bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      armed_q, armed_d;
    logic                      push_c, ferr_set;
    logic                      ferr_q, ferr_d, oerr_q, oerr_d, perr_d, irq_q, irq_d;
    logic                      fifo_valid_d, fifo_drop;
`ifdef UART_RX_PARITY_EN
    logic                      par_bad_q, par_bad_d, perr_set, perr_q;
`endif

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign div_lim = (clk_div < 16'(UART_MIN_DIV)) ? 16'(UART_MIN_DIV) : clk_div;

    // armed_q: line must be seen idle-high before a falling edge counts as a start
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        armed_d  = armed_q;
        push_c   = 1'b0;
        ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_set  = 1'b0;
`endif
        if (!rx_en) begin
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            armed_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rxs) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        div_d   = div_lim;
                        cnt_d   = div_lim >> 1;
                        state_d = START;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end
                end
                START: begin
                    if (cnt_q != '0) begin
                        cnt_d = 16'(cnt_q - 16'd1);
                    end else if (!rxs) begin
                        cnt_d   = 16'(div_q - 16'd1);
                        bit_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    if (cnt_q != '0) begin
                        cnt_d = 16'(cnt_q - 16'd1);
                    end else begin
                        shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
                        cnt_d   = 16'(div_q - 16'd1);
                        bit_d   = BW'(bit_q + BW'(1));
                        if (bit_q == BW'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q != '0) begin
                        cnt_d = 16'(cnt_q - 16'd1);
                    end else begin
                        perr_set  = (rxs != ^shift_q);
                        par_bad_d = perr_set;
                        cnt_d     = 16'(div_q - 16'd1);
                        state_d   = STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt_q != '0) begin
                        cnt_d = 16'(cnt_q - 16'd1);
                    end else begin
                        if (rxs) begin
`ifdef UART_RX_PARITY_EN
                            push_c = !par_bad_q;
`else
                            push_c = 1'b1;
`endif
                        end else begin
                            ferr_set = 1'b1;
                            armed_d  = 1'b0;
                        end
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push_i    (push_c),
        .data_i    (shift_q),
        .pop_i     (bus.rd_en),
        .data_o    (bus.rd_data),
        .valid_o   (bus.rx_valid),
        .full_o    (bus.fifo_full),
        .valid_d_c (fifo_valid_d),
        .drop_c    (fifo_drop)
    );

    // New errors win over a simultaneous clear
    always_comb begin
        ferr_d = ferr_set || (ferr_q && !bus.err_clr);
        oerr_d = fifo_drop || (oerr_q && !bus.err_clr);
`ifdef UART_RX_PARITY_EN
        perr_d = perr_set || (perr_q && !bus.err_clr);
`else
        perr_d = 1'b0;
`endif
        irq_d  = fifo_valid_d || ferr_d || oerr_d || perr_d;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync_q  <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 16'(UART_MIN_DIV);
            bit_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
            irq_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
            irq_q   <= irq_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign bus.frame_err   = ferr_q;
    assign bus.overrun_err = oerr_q;
    assign bus.irq         = irq_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err  = perr_q;
`else
    assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_core.sv
// Bench for uart_rx_fifo_core: drives 8N1 frames and compares every cycle
// against a queue-based model of received characters, FIFO and error flags.
module tb_uart_rx_fifo_core;

    localparam int unsigned DEPTH = 4;
    localparam longint unsigned S = 2;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        rx_i    = 1'b1;
    logic        rx_en   = 1'b0;
    logic [15:0] clk_div = 16'd16;
    logic        rd_en   = 1'b0;
    logic        err_clr = 1'b0;

    uart_rx_fifo_core_if bus ();
    assign bus.rd_en   = rd_en;
    assign bus.err_clr = err_clr;

    uart_rx_fifo_core #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .rx_i     (rx_i),
        .rx_en    (rx_en),
        .clk_div  (clk_div),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: each complete frame resolves at its stop-sample edge into a push or a frame error
    typedef struct {
        longint unsigned edge_n;
        logic [7:0]      data;
        bit              ok;
    } ev_t;

    ev_t             ev_q[$];
    int              ev_rd = 0;
    logic [7:0]      mq[$];
    bit              m_ferr = 0, m_oerr = 0, m_push, m_fe, m_oe;
    logic [7:0]      m_pd;
    longint unsigned cyc = 0;
    bit              run_cmp = 0;
    bit              rand_mode = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ferr = 0;
            m_oerr = 0;
            ev_rd  = ev_q.size();
        end else begin
            cyc++;
            m_push = 0;
            m_fe   = 0;
            m_oe   = 0;
            m_pd   = 8'h00;
            while (ev_rd < ev_q.size() && ev_q[ev_rd].edge_n <= cyc) begin
                if (ev_q[ev_rd].edge_n == cyc) begin
                    if (ev_q[ev_rd].ok) begin
                        m_push = 1;
                        m_pd   = ev_q[ev_rd].data;
                    end else begin
                        m_fe = 1;
                    end
                end
                ev_rd++;
            end
            if (rd_en && mq.size() > 0) void'(mq.pop_front());
            if (m_push) begin
                if (mq.size() < DEPTH) mq.push_back(m_pd);
                else m_oe = 1;
            end
            m_ferr = m_fe || (m_ferr && !err_clr);
            m_oerr = m_oe || (m_oerr && !err_clr);
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("rd_data",     32'(bus.rd_data),     32'((mq.size() > 0) ? mq[0] : 8'h00));
            check("rx_valid",    32'(bus.rx_valid),    32'(mq.size() > 0));
            check("fifo_full",   32'(bus.fifo_full),   32'(mq.size() == DEPTH));
            check("frame_err",   32'(bus.frame_err),   32'(m_ferr));
            check("overrun_err", 32'(bus.overrun_err), 32'(m_oerr));
            check("parity_err",  32'(bus.parity_err),  32'(0));
            check("irq",         32'(bus.irq),         32'((mq.size() > 0) || m_ferr || m_oerr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            rd_en   = ($urandom_range(0, 5) == 0);
            err_clr = ($urandom_range(0, 30) == 0);
        end
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) tick();
    endtask

    function automatic longint unsigned eff_div(input logic [15:0] d);
        return (d < 16'd4) ? 64'd4 : longint'(d);
    endfunction

    // Drive the first nb bits of a frame; a whole frame is scheduled at its stop-sample edge
    task automatic send(input logic [7:0] b, input bit stop, input int nb,
                        input bit pop_at_stop, input bit div_jitter);
        longint unsigned d = eff_div(clk_div);
        longint unsigned f = cyc + 1;
        longint unsigned e = f + S + (d >> 1) + 1 + 9 * d;
        logic [9:0] fr = {stop, b, 1'b0};
        if (nb == 10) ev_q.push_back('{e, b, stop});
        for (int k = 0; k < nb; k++) begin
            rx_i = fr[k];
            if (div_jitter && k == 3) clk_div = 16'($urandom_range(1, 24));
            for (longint unsigned c = 0; c < d; c++) begin
                tick();
                if (pop_at_stop) rd_en = (cyc + 1 == e);
            end
        end
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        check(name, 32'(bus.rd_data), 32'(exp));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] basic [4];
        basic[0] = 8'd61; basic[1] = 8'd15; basic[2] = 8'd29; basic[3] = 8'd36;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_data",  32'(bus.rd_data),  32'h00);
        check("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
        check("reset_irq",      32'(bus.irq),      32'h0);
        rst = 1'b0;
        run_cmp = 1;
        rx_en = 1'b1;
        idle(20);

        // Four characters fill the FIFO in arrival order
        clk_div = 16'd16;
        for (int i = 0; i < 4; i++) begin
            send(basic[i], 1'b1, 10, 1'b0, 1'b0);
            idle(20);
        end
        check("basic_full", 32'(bus.fifo_full), 32'h1);
        check("basic_head", 32'(bus.rd_data),   32'd61);

        // Full FIFO drops the next byte and flags overrun
        send(8'hA5, 1'b1, 10, 1'b0, 1'b0);
        idle(20);
        check("overrun_flag", 32'(bus.overrun_err), 32'h1);
        check("overrun_irq",  32'(bus.irq),         32'h1);
        check("overrun_head", 32'(bus.rd_data),     32'd61);
        clear_errs();
        check("clr_overrun",  32'(bus.overrun_err), 32'h0);
        check("clr_irq_held", 32'(bus.irq),         32'h1);

        // Pop in the stop-sample cycle makes room for the new byte
        send(8'h3C, 1'b1, 10, 1'b1, 1'b0);
        idle(20);
        check("pp_no_overrun", 32'(bus.overrun_err), 32'h0);
        check("pp_full",       32'(bus.fifo_full),   32'h1);
        pop_expect("pop_15", 8'd15);
        pop_expect("pop_29", 8'd29);
        pop_expect("pop_36", 8'd36);
        pop_expect("pop_3c", 8'h3C);
        check("drained_valid", 32'(bus.rx_valid), 32'h0);
        check("drained_irq",   32'(bus.irq),      32'h0);

        // Low stop bit: flag, no push; line stays low so no false restart
        send(8'h55, 1'b0, 10, 1'b0, 1'b0);
        rx_i = 1'b0;
        repeat (16) tick();
        idle(16);
        check("ferr_flag",  32'(bus.frame_err), 32'h1);
        check("ferr_empty", 32'(bus.rx_valid),  32'h0);
        send(8'h5A, 1'b1, 10, 1'b0, 1'b0);
        idle(20);
        pop_expect("after_ferr", 8'h5A);
        clear_errs();

        // Short low pulse is rejected as a glitch
        rx_i = 1'b0;
        repeat (6) tick();
        idle(40);
        check("glitch_empty", 32'(bus.rx_valid),  32'h0);
        check("glitch_noerr", 32'(bus.frame_err), 32'h0);

        // Disable during bit 3 abandons the frame
        send(8'hAA, 1'b1, 4, 1'b0, 1'b0);
        rx_i = 1'b1;
        repeat (8) tick();
        rx_en = 1'b0;
        repeat (8) tick();
        idle(40);
        rx_en = 1'b1;
        idle(20);
        check("disable_empty", 32'(bus.rx_valid), 32'h0);
        send(8'h81, 1'b1, 10, 1'b0, 1'b0);
        idle(20);
        pop_expect("reenable_81", 8'h81);

        // Divisor below the minimum runs at 4 clocks per bit
        clk_div = 16'd1;
        send(8'hFF, 1'b1, 10, 1'b0, 1'b0);
        idle(8);
        send(8'h96, 1'b1, 10, 1'b0, 1'b0);
        idle(8);
        pop_expect("clamp_ff", 8'hFF);
        pop_expect("clamp_96", 8'h96);

        // Reset mid-frame with data and an error pending
        clk_div = 16'd16;
        send(8'h55, 1'b0, 10, 1'b0, 1'b0);
        idle(20);
        send(8'h12, 1'b1, 10, 1'b0, 1'b0);
        idle(20);
        send(8'h34, 1'b1, 5, 1'b0, 1'b0);
        check("prerst_valid", 32'(bus.rx_valid),  32'h1);
        check("prerst_ferr",  32'(bus.frame_err), 32'h1);
        rst = 1'b1;
        #2;
        check("rst_rd_data", 32'(bus.rd_data),   32'h00);
        check("rst_valid",   32'(bus.rx_valid),  32'h0);
        check("rst_ferr",    32'(bus.frame_err), 32'h0);
        check("rst_irq",     32'(bus.irq),       32'h0);
        rx_i = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        idle(20);
        send(8'h77, 1'b1, 10, 1'b0, 1'b0);
        idle(20);
        pop_expect("postrst_77", 8'h77);

        // Random characters, divisors, bad stops, pops and clears
        rand_mode = 1;
        repeat (30) begin
            logic [7:0]      b;
            bit              st;
            longint unsigned d;
            clk_div = 16'($urandom_range(1, 24));
            d  = eff_div(clk_div);
            b  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 7) != 0);
            send(b, st, 10, 1'b0, 1'($urandom_range(0, 1)));
            idle(int'(d) + 2 + int'($urandom_range(0, 20)));
        end
        rand_mode = 0;
        rd_en = 1'b0;
        err_clr = 1'b0;
        idle(5);
        for (int i = 0; i < DEPTH; i++) begin
            if (mq.size() > 0) begin
                rd_en = 1'b1;
                tick();
                rd_en = 1'b0;
            end
        end
        tick();
        check("final_empty", 32'(bus.rx_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
